// File: rtl/extrema_tracker.sv
// Running max/min/count tracker that time-shares one external 8-bit comparator.
// Each non-first sample gets a max compare, then a min compare, each held SETTLE cycles.
module extrema_tracker #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic [WIDTH-1:0] cmp_aa,
    output logic [WIDTH-1:0] cmp_bb,
    input  logic             cmp_ee,
    input  logic             cmp_gg,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [CNT_W-1:0] count_out,
    output logic             stats_valid,
    output logic             busy
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP_MAX = 2'd1,
        CMP_MIN = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sample;
    logic [SET_W-1:0] settle_cnt;

    logic take_c;
    logic settle_done_c;
    logic above_c;
    logic below_c;

    assign take_c        = in_valid && in_ready;
    assign settle_done_c = (settle_cnt == SETTLE_LAST);
    // EE wins over GG, so the illegal EE&GG pair reads as "equal" and updates nothing
    assign above_c       = cmp_gg && !cmp_ee;
    assign below_c       = !cmp_gg && !cmp_ee;

    // Comparator results are only consulted on the final settle edge of a phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            cmp_aa      <= '0;
            cmp_bb      <= '0;
            max_out     <= '0;
            min_out     <= '1;
            count_out   <= '0;
            stats_valid <= 1'b0;
            sample      <= '0;
            settle_cnt  <= '0;
        end else if (clr) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            max_out     <= '0;
            min_out     <= '1;
            count_out   <= '0;
            stats_valid <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_c) begin
                        sample <= in_data;
                        if (!stats_valid) begin
                            max_out     <= in_data;
                            min_out     <= in_data;
                            count_out   <= CNT_W'(1);
                            stats_valid <= 1'b1;
                        end else begin
                            state      <= CMP_MAX;
                            cmp_aa     <= in_data;
                            cmp_bb     <= max_out;
                            settle_cnt <= '0;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                CMP_MAX: begin
                    if (settle_done_c) begin
                        if (above_c) begin
                            max_out <= sample;
                        end
                        state      <= CMP_MIN;
                        cmp_bb     <= min_out;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                CMP_MIN: begin
                    if (settle_done_c) begin
                        if (below_c) begin
                            min_out <= sample;
                        end
                        if (count_out != '1) begin
                            count_out <= count_out + CNT_W'(1);
                        end
                        state      <= IDLE;
                        settle_cnt <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    settle_cnt <= '0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/extrema_tracker.md
Name: extrema_tracker

Overview:
- Sequential stage directly upstream and downstream of the 8-bit comparator circuit (EE = aa equals bb, GG = aa greater than bb).
- Accepts a stream of 8-bit samples over a valid/ready handshake and drives each sample onto the comparator's aa/bb inputs.
- Waits a programmable settle time, then consumes EE/GG to maintain the running maximum, running minimum and sample count.
- One shared comparator instance is time-multiplexed: max compare first, then min compare.

Parameters:
- WIDTH, 8, sample and comparator operand width.
- SETTLE, 4, clock cycles each operand pair is held stable before EE/GG are sampled. Minimum legal value is 1.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  sample value.
- clr  in  1  synchronous clear of statistics.
- cmp_aa  out  WIDTH  comparator operand aa.
- cmp_bb  out  WIDTH  comparator operand bb.
- cmp_ee  in  1  comparator EE result.
- cmp_gg  in  1  comparator GG result.
- max_out  out  WIDTH  running maximum.
- min_out  out  WIDTH  running minimum.
- count_out  out  CNT_W  samples processed.
- stats_valid  out  1  at least one sample has been processed.
- busy  out  1  compare in progress.

Behaviour:
- Reset (async, rst_n=0) values:
  - state IDLE; in_ready=1, busy=0.
  - cmp_aa=0, cmp_bb=0.
  - max_out=0, min_out=all-ones, count_out=0, stats_valid=0.
  - Sample latch=0, settle counter=0.
- Reset mid-operation aborts immediately; the in-flight sample is discarded.
- States: IDLE, CMP_MAX, CMP_MIN.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid and in_ready at a rising edge) latches in_data.
  - If stats_valid=0 (first sample): max_out, min_out and sample are loaded at that same edge, count_out becomes 1, stats_valid becomes 1, and the state stays IDLE. No compare is made.
  - Otherwise: go to CMP_MAX, with cmp_aa=sample, cmp_bb=max_out, settle counter=0.
- CMP_MAX:
  - busy=1, in_ready=0.
  - Counter increments each cycle. On the edge where counter = SETTLE-1, sample cmp_ee/cmp_gg.
  - If gg=1 and ee=0, max_out is set to sample.
  - Then go to CMP_MIN, with cmp_bb=min_out (the pre-update value) and counter=0. cmp_aa is unchanged.
- CMP_MIN:
  - Same timing as CMP_MAX.
  - If gg=0 and ee=0, min_out is set to sample.
  - At the same edge: count_out increments (saturates at all-ones, no wrap); go to IDLE.
- Latency: a handshake at edge T completes at edge T+2·SETTLE. in_ready returns high in the cycle after that edge. Throughput is one sample per 2·SETTLE+1 cycles.
- cmp_aa/cmp_bb change only on phase entry and otherwise hold their value, including in IDLE. This keeps the gate-level comparator quiet.
- cmp_ee=1 and cmp_gg=1 together is illegal and is treated as equal: no update.
- Unknown or X comparator results are never sampled outside the SETTLE-1 edge.
- clr=1 at an edge, in any state and with priority over a handshake:
  - state=IDLE; max_out=0, min_out=all-ones, count_out=0, stats_valid=0.
  - Any in-flight sample is dropped. cmp_aa/cmp_bb hold.
- in_data is ignored except at handshake edges.
- in_valid may drop without a handshake; no state change results.

Test Plan:
- Reset then single sample 0x5A -> at the next edge max_out=0x5A, min_out=0x5A, count_out=1, stats_valid=1, busy never asserted.
- Samples 0x5A, 0x80, 0x10 with SETTLE=4 and a behavioural comparator model -> final max_out=0x80, min_out=0x10, count_out=3. Each non-first sample: in_ready low for exactly 8 cycles; cmp_aa/cmp_bb show (0x80,0x5A), (0x80,0x5A), then (0x10,0x80), (0x10,0x5A).
- Equal sample 0x5A after 0x5A -> max_out and min_out unchanged, count_out=2. Forcing cmp_ee=cmp_gg=1 on a different sample -> no update.
- clr asserted during CMP_MAX of the second sample -> next cycle state IDLE, count_out=0, stats_valid=0, max_out=0x00, min_out=0xFF. The following sample 0x33 loads as a first sample.
- rst_n pulsed low mid-CMP_MIN (asynchronously, between edges) -> outputs reach reset values immediately, without waiting for clk. After release, in_ready=1.
- CNT_W=2, feed 5 samples -> count_out saturates at 3. max/min remain correct. in_valid held high continuously is accepted only when in_ready=1.
